popcount_frame_acc: RTL
=======================

POPCOUNT_FRAME_ACC -- requirements
Module: popcount_frame_acc

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of frame bit-count accumulator (min 4).
REQ-002 SHALL have parameter LEN_W, default 12: width of frame byte counter (min 1).
REQ-003 SHALL have input CLK, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have input ASYNCRESETN, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have input I_data, 8 bits: input byte.
REQ-006 SHALL have input I_valid, 1 bit: I_data/I_last valid.
REQ-007 SHALL have input I_last, 1 bit: byte is final byte of frame.
REQ-008 SHALL have output I_ready, 1 bit: block accepts a byte this cycle.
REQ-009 SHALL have input CLR, 1 bit: synchronous abort of current frame.
REQ-010 SHALL have output O_count, CNT_W bits: total set bits in frame.
REQ-011 SHALL have output O_len, LEN_W bits: bytes in frame.
REQ-012 SHALL have output O_sat, 1 bit: O_count or O_len saturated.
REQ-013 SHALL have output O_valid, 1 bit: result fields valid.
REQ-014 SHALL have input O_ready, 1 bit: consumer takes result.

Function
REQ-015 SHALL treat a byte as accepted when I_valid and I_ready are both high at a rising CLK edge.
REQ-016 SHALL implement FSM states ACCUM and HOLD; ACCUM on reset.
REQ-017 SHALL drive I_ready=1 in ACCUM, 0 in HOLD, combinationally from state only (no dependence on I_valid).
REQ-018 SHALL, per accepted non-last byte in ACCUM: acc += popcount(I_data), len += 1.
REQ-019 SHALL, on accepted last byte: load O_count=acc+popcount(I_data), O_len=len+1, O_sat=sticky sat, clear acc/len/sat, enter HOLD; O_valid high the next cycle (latency 1).
REQ-020 SHALL hold O_count/O_len/O_sat/O_valid stable in HOLD until O_valid&&O_ready, then return to ACCUM with O_valid=0 next cycle; I_ready=1 from that cycle.
REQ-021 SHALL saturate acc at 2^CNT_W-1 and len at 2^LEN_W-1, setting sticky sat flag on any clamp.
REQ-022 SHALL, with CLR high in ACCUM, clear acc/len/sat and ignore any byte accepted in the same cycle.
REQ-023 SHALL ignore CLR in HOLD (pending result is never discarded).
REQ-024 SHALL report a single-byte frame (I_last on first byte) with O_len=1.
REQ-025 SHALL keep O_count/O_len/O_sat at their last loaded values while O_valid=0 (not X).

Reset
REQ-026 SHALL on ASYNCRESETN low immediately force state=ACCUM, acc=0, len=0, sat=0, O_count=0, O_len=0, O_sat=0, O_valid=0.
REQ-027 SHALL drive I_ready=1 during and after reset; reset mid-frame or in HOLD discards all frame and result data.
REQ-028 SHALL release reset synchronously-safe: first byte accepted on first CLK edge after ASYNCRESETN rises counts normally.

Structure
REQ-029 SHALL place FSM state encoding (ACCUM=0, HOLD=1) and CNT_W/LEN_W defaults in shared package popcount_pkg.
REQ-030 SHALL instantiate existing combinational sub-module PopCount8 (8-bit in, 4-bit out) on I_data; no other sub-modules.
REQ-031 SHALL zero-extend the 4-bit popcount to CNT_W+1 bits before addition for saturation detection.

Verification
REQ-032 Frame 0xFF,0x01,0x00(last), O_ready=1 -> O_valid one cycle after last; O_count=9, O_len=3, O_sat=0.
REQ-033 Single byte 0xA5 with I_last -> O_count=4, O_len=1; I_ready=0 while O_ready held low 5 cycles, result stable throughout.
REQ-034 CNT_W=4, frame 0xFF,0xFF(last) -> O_count=15, O_sat=1; next frame 0x03(last) -> O_count=2, O_sat=0.
REQ-035 Bytes 0x0F,0x0F then CLR with 0xFF valid, then 0x01(last) -> O_count=1, O_len=1.
REQ-036 ASYNCRESETN low mid-frame after 0xFF, and again in HOLD -> all outputs 0, O_valid=0, I_ready=1 immediately; next frame 0x80(last) -> O_count=1.
REQ-037 Random back-to-back frames with random I_valid/O_ready gaps -> results match reference model sum, no lost/duplicated bytes or results.

Source files
------------

// File: rtl/popcount_pkg.sv
// popcount_pkg: shared FSM encoding and default widths for the frame popcount accumulator
package popcount_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int LEN_W_DEF = 12;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/PopCount8.sv
// PopCount8: number of set bits in a byte
module PopCount8 (
  input  logic [7:0] data,
  output logic [3:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) count = count + {3'b0, data[i]};
  end
endmodule

// File: rtl/popcount_frame_acc.sv
// popcount_frame_acc: per-frame saturating bit-count and byte-count accumulator with held result
module popcount_frame_acc
  import popcount_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [7:0]       I_data,
  input  logic             I_valid,
  input  logic             I_last,
  output logic             I_ready,
  input  logic             CLR,
  output logic [CNT_W-1:0] O_count,
  output logic [LEN_W-1:0] O_len,
  output logic             O_sat,
  output logic             O_valid,
  input  logic             O_ready
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] acc, acc_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic sat, sat_nxt, take;
  logic [3:0] pc;
  logic [CNT_W:0] acc_sum;
  logic [LEN_W:0] len_sum;
  PopCount8 u_pc (.data(I_data), .count(pc));
  // one extra bit on each sum exposes the carry that triggers clamping
  assign acc_sum = {1'b0, acc} + {{(CNT_W-3){1'b0}}, pc};
  assign len_sum = {1'b0, len} + {{LEN_W{1'b0}}, 1'b1};
  assign acc_nxt = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
  assign len_nxt = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
  assign sat_nxt = sat | acc_sum[CNT_W] | len_sum[LEN_W];
  always_ff @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) state <= ACCUM;
    else state <= state_nxt;
  always_comb begin
    I_ready = state == ACCUM;
    O_valid = state == HOLD;
    take = I_valid & I_ready & ~CLR;
    state_nxt = state;
    if (take && I_last) state_nxt = HOLD;
    else if (O_valid && O_ready) state_nxt = ACCUM;
  end
  always_ff @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) begin
      acc <= '0;
      len <= '0;
      sat <= 1'b0;
      O_count <= '0;
      O_len <= '0;
      O_sat <= 1'b0;
    end else if (I_ready && CLR) begin
      acc <= '0;
      len <= '0;
      sat <= 1'b0;
    end else if (take && I_last) begin
      O_count <= acc_nxt;
      O_len <= len_nxt;
      O_sat <= sat_nxt;
      acc <= '0;
      len <= '0;
      sat <= 1'b0;
    end else if (take) begin
      acc <= acc_nxt;
      len <= len_nxt;
      sat <= sat_nxt;
    end
endmodule
